mixcolum_iter: RTL

- Parametrised, handshaked successor to the 4-cycle single-word MixColumns unit in the AES datapath.
- Captures a 128-bit state on acceptance and processes COLS_PER_CYCLE columns per cycle using replicated word-mix lanes.
- Mode (encrypt MixColumns / decrypt InvMixColumns) is selected per block.
- Holds the result under valid/ready backpressure, so round control can stall downstream without losing data.

---
 rtl/mixcolum_iter_if.sv | 22 ++
 rtl/mixcolum_iter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mixcolum_iter_if.sv
// Handshake bundle for the iterative MixColumns unit: input acceptance, result
// delivery and a busy indication.
interface mixcolum_iter_if;
  logic         decrypt_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] data_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] data_o;
  logic         busy_o;

  modport master (
    output decrypt_i, in_valid_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, busy_o
  );

  modport slave (
    input  decrypt_i, in_valid_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, busy_o
  );
endinterface

// File: rtl/mixcolum_iter.sv
// Iterative AES (Inv)MixColumns: captures a 128-bit state, mixes COLS_PER_CYCLE
// columns per cycle and holds the result under valid/ready backpressure.
module mixcolum_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            reset,
  mixcolum_iter_if.slave bus
);

  localparam int unsigned PASSES  = (COLS_PER_CYCLE == 0) ? 4 : 4 / COLS_PER_CYCLE;
  localparam logic [1:0]  LastCnt = 2'(PASSES - 1);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mixcolum_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] src_q, src_d;
  logic         mode_q, mode_d;
  logic [127:0] res_q, res_d;
  logic [127:0] data_q, data_d;
  logic [127:0] mixed;
  logic         in_ready;
  int           base;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One output byte from a column rotated so that a0 is the byte being produced.
  function automatic logic [7:0] mix_byte(input logic [7:0] a0, input logic [7:0] a1,
                                          input logic [7:0] a2, input logic [7:0] a3,
                                          input logic inv);
    logic [7:0] a0x2, a0x4, a0x8, a1x2, a1x4, a1x8, a2x2, a2x4, a2x8, a3x2, a3x4, a3x8;
    a0x2 = xtime(a0); a0x4 = xtime(a0x2); a0x8 = xtime(a0x4);
    a1x2 = xtime(a1); a1x4 = xtime(a1x2); a1x8 = xtime(a1x4);
    a2x2 = xtime(a2); a2x4 = xtime(a2x2); a2x8 = xtime(a2x4);
    a3x2 = xtime(a3); a3x4 = xtime(a3x2); a3x8 = xtime(a3x4);
    if (!inv) return a0x2 ^ a1x2 ^ a1 ^ a2 ^ a3;
    return (a0x8 ^ a0x4 ^ a0x2) ^ (a1x8 ^ a1x2 ^ a1) ^ (a2x8 ^ a2x4 ^ a2) ^ (a3x8 ^ a3);
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] w, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {mix_byte(a0, a1, a2, a3, inv), mix_byte(a1, a2, a3, a0, inv),
            mix_byte(a2, a3, a0, a1, inv), mix_byte(a3, a0, a1, a2, inv)};
  endfunction

  // Replicated lanes: this pass covers columns cnt*N .. cnt*N+N-1.
  always_comb begin
    mixed = res_q;
    base  = 0;
    for (int l = 0; l < int'(COLS_PER_CYCLE); l++) begin
      base = 96 - 32 * (int'(cnt_q) * int'(COLS_PER_CYCLE) + l);
      mixed[base +: 32] = mix_word(src_q[base +: 32], mode_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    mode_d   = mode_q;
    res_d    = res_q;
    data_d   = data_q;
    in_ready = 1'b0;
    unique case (state_q)
      StIdle: in_ready = 1'b1;
      StCalc: begin
        res_d = mixed;
        if (cnt_q == LastCnt) begin
          data_d  = mixed;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StDone: begin
        in_ready = bus.out_ready_i;
        if (bus.out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Capture covers both the idle accept and the back-to-back accept from DONE.
    if (in_ready && bus.in_valid_i) begin
      src_d   = bus.data_i;
      mode_d  = bus.decrypt_i;
      cnt_d   = '0;
      state_d = StCalc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      src_q   <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = (state_q == StDone);
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.data_o      = data_q;

endmodule
